axil_mst: RTL and testbench



---
 rtl/axil_pkg.sv | 30 +++
 rtl/axil_mst.sv | 210 +++++++++++++++++++++
 tb/tb_axil_mst.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared types for the AXI-Lite master: FSM state encoding and AXI response codes.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } axil_mst_st_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // SLVERR and DECERR both carry resp[1]; the core only sees a single error bit.
  function automatic logic resp_is_err(input logic [1:0] resp);
    logic err;
    err = 1'b0;
    case (resp)
      OKAY, EXOKAY:   err = 1'b0;
      SLVERR, DECERR: err = 1'b1;
      default:        err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/axil_mst.sv
// Single-outstanding AXI-Lite master: turns a core req/rsp port into AW/W/B and AR/R
// transactions. Every handshake output is a register, so nothing is combinational from AXI.
module axil_mst
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req_val,
  output logic                  req_rdy,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdat,
  input  logic [STRB_WIDTH-1:0] req_wstrb,

  output logic                  rsp_val,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_dat,
  output logic                  rsp_err,

  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,

  output logic [DATA_WIDTH-1:0] axi_wdata,
  output logic [STRB_WIDTH-1:0] axi_wstrb,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,

  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,

  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,

  input  logic [DATA_WIDTH-1:0] axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rvalid,
  output logic                  axi_rready
);

  axil_mst_st_t          state_q,   state_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [DATA_WIDTH-1:0] wdat_q,    wdat_d;
  logic [STRB_WIDTH-1:0] wstrb_q,   wstrb_d;
  logic                  req_rdy_q, req_rdy_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q,  wvalid_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q,  w_done_d;
  logic                  bready_q,  bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q,  rready_d;
  logic                  rsp_val_q, rsp_val_d;
  logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic                  rsp_err_q, rsp_err_d;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    rsp_val_d = rsp_val_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (req_val && req_rdy_q) begin
          addr_d  = req_addr;
          wdat_d  = req_wdat;
          wstrb_d = req_wstrb;
          if (req_we) begin
            state_d   = WR_ADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end

      // AW and W complete independently; B is only opened once both are done.
      WR_ADDR: begin
        if (awvalid_q && axi_awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && axi_wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end

      WR_RESP: begin
        if (axi_bvalid && bready_q) begin
          bready_d  = 1'b0;
          rsp_dat_d = '0;
          rsp_err_d = resp_is_err(axi_bresp);
          rsp_val_d = 1'b1;
          state_d   = RSP;
        end
      end

      RD_ADDR: begin
        if (arvalid_q && axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (axi_rvalid && rready_q) begin
          rready_d  = 1'b0;
          rsp_dat_d = axi_rdata;
          rsp_err_d = resp_is_err(axi_rresp);
          rsp_val_d = 1'b1;
          state_d   = RSP;
        end
      end

      RSP: begin
        if (rsp_rdy) begin
          rsp_val_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Registered decode of the next state: low in reset, high from the first edge after it.
    req_rdy_d = (state_d == IDLE);
  end

  // NOTE: the datapath registers are reset too, because every AXI address/data output must read 0 in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdat_q    <= '0;
      wstrb_q   <= '0;
      req_rdy_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rsp_val_q <= 1'b0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the same pre-edge values.
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      wstrb_q   <= wstrb_d;
      req_rdy_q <= req_rdy_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      rsp_val_q <= rsp_val_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign req_rdy     = req_rdy_q;
  assign rsp_val     = rsp_val_q;
  assign rsp_dat     = rsp_dat_q;
  assign rsp_err     = rsp_err_q;
  assign axi_awaddr  = addr_q;
  assign axi_awvalid = awvalid_q;
  assign axi_wdata   = wdat_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_bready  = bready_q;
  assign axi_araddr  = addr_q;
  assign axi_arvalid = arvalid_q;
  assign axi_rready  = rready_q;

endmodule

// File: tb/tb_axil_mst.sv
// Bench for axil_mst: a behavioural AXI-Lite slave with per-channel delays, a request-level
// reference memory, directed latency/ordering/error/reset cases, then randomized traffic.
module tb_axil_mst;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic          clk;
  logic          rst;
  logic          req_val, req_rdy, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdat;
  logic [SW-1:0] req_wstrb;
  logic          rsp_val, rsp_rdy, rsp_err;
  logic [DW-1:0] rsp_dat;
  logic [AW-1:0] axi_awaddr;
  logic          axi_awvalid, axi_awready;
  logic [DW-1:0] axi_wdata;
  logic [SW-1:0] axi_wstrb;
  logic          axi_wvalid, axi_wready;
  logic [1:0]    axi_bresp;
  logic          axi_bvalid, axi_bready;
  logic [AW-1:0] axi_araddr;
  logic          axi_arvalid, axi_arready;
  logic [DW-1:0] axi_rdata;
  logic [1:0]    axi_rresp;
  logic          axi_rvalid, axi_rready;

  axil_mst #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rdy(req_rdy), .req_we(req_we), .req_addr(req_addr),
    .req_wdat(req_wdat), .req_wstrb(req_wstrb),
    .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  // Slave configuration and per-transaction state.
  int         aw_dly, w_dly, b_dly, ar_dly, r_dly;
  int         aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, b_count;
  bit         aw_got, w_got, ar_got, b_on, b_done, r_on, r_done;
  bit         aw_pend, w_pend, ar_pend;
  logic [1:0] cur_resp;
  logic [31:0] cur_rdata;
  logic [31:0] got_awaddr, got_wdata, got_araddr, pend_awaddr, pend_wdata, pend_araddr;
  logic [3:0]  got_wstrb, pend_wstrb;
  int          t_aw_first, t_w_first, t_aw_hs, t_w_hs, t_b_first, t_ar_first, t_r_first, t_rsp;

  logic [31:0] smem [16];  // what the slave holds, written only from observed AXI traffic
  logic [31:0] rmem [16];  // what the requester expects, written from its own requests

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic slave_clear();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; b_count = 0;
    aw_got = 0; w_got = 0; ar_got = 0; b_on = 0; b_done = 0; r_on = 0; r_done = 0;
    aw_pend = 0; w_pend = 0; ar_pend = 0;
    t_aw_first = -1; t_w_first = -1; t_aw_hs = -1; t_w_hs = -1;
    t_b_first = -1; t_ar_first = -1; t_r_first = -1;
    axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 2'b00;
    axi_arready = 0; axi_rvalid = 0; axi_rresp = 2'b00; axi_rdata = '0;
  endtask

  // Runs at each falling edge: checks protocol against history, then decides what the
  // slave drives for the coming rising edge and which handshakes that edge completes.
  task automatic slave_step();
    int rel;
    rel = cyc - acc_cyc;
    if (aw_pend) begin
      check("aw_hold", axi_awvalid, 1'b1);
      check("aw_addr_stable", axi_awaddr, pend_awaddr);
    end
    if (w_pend) begin
      check("w_hold", axi_wvalid, 1'b1);
      check("w_data_stable", {axi_wdata, axi_wstrb}, {pend_wdata, pend_wstrb});
    end
    if (ar_pend) begin
      check("ar_hold", axi_arvalid, 1'b1);
      check("ar_addr_stable", axi_araddr, pend_araddr);
    end
    if (axi_awvalid) check("aw_once", aw_got, 1'b0);
    if (axi_wvalid)  check("w_once", w_got, 1'b0);
    if (axi_arvalid) check("ar_once", ar_got, 1'b0);
    if (axi_bready)  check("b_after_aw_w", aw_got && w_got, 1'b1);

    if (axi_awvalid && t_aw_first < 0) t_aw_first = rel;
    if (axi_wvalid  && t_w_first  < 0) t_w_first  = rel;
    if (axi_bready  && t_b_first  < 0) t_b_first  = rel;
    if (axi_arvalid && t_ar_first < 0) t_ar_first = rel;
    if (axi_rready  && t_r_first  < 0) t_r_first  = rel;

    axi_awready = 0;
    if (axi_awvalid && !aw_got) begin
      if (aw_cnt >= aw_dly) begin
        axi_awready = 1; aw_got = 1; got_awaddr = axi_awaddr; t_aw_hs = rel;
      end
      aw_cnt++;
    end
    aw_pend = axi_awvalid && !axi_awready;
    pend_awaddr = axi_awaddr;

    axi_wready = 0;
    if (axi_wvalid && !w_got) begin
      if (w_cnt >= w_dly) begin
        axi_wready = 1; w_got = 1; got_wdata = axi_wdata; got_wstrb = axi_wstrb; t_w_hs = rel;
      end
      w_cnt++;
    end
    w_pend = axi_wvalid && !axi_wready;
    pend_wdata = axi_wdata;
    pend_wstrb = axi_wstrb;

    if (aw_got && w_got && !b_done && !b_on) begin
      if (b_cnt >= b_dly) b_on = 1;
      else b_cnt++;
    end
    axi_bvalid = b_on;
    axi_bresp  = b_on ? cur_resp : 2'($urandom);
    if (b_on && axi_bready) begin
      b_on = 0; b_done = 1; b_count++;
      if (!cur_resp[1]) smem[got_awaddr[5:2]] = merge(smem[got_awaddr[5:2]], got_wdata, got_wstrb);
    end

    axi_arready = 0;
    if (axi_arvalid && !ar_got) begin
      if (ar_cnt >= ar_dly) begin
        axi_arready = 1; ar_got = 1; got_araddr = axi_araddr;
        cur_rdata = smem[axi_araddr[5:2]];
      end
      ar_cnt++;
    end
    ar_pend = axi_arvalid && !axi_arready;
    pend_araddr = axi_araddr;

    if (ar_got && !r_done && !r_on) begin
      if (r_cnt >= r_dly) r_on = 1;
      else r_cnt++;
    end
    axi_rvalid = r_on;
    axi_rdata  = r_on ? cur_rdata : $urandom;
    axi_rresp  = r_on ? cur_resp : 2'($urandom);
    if (r_on && axi_rready) begin
      r_on = 0; r_done = 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    slave_step();
  endtask

  // One full request/response; cycle 0 is the accept cycle.
  task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [1:0] resp,
                        input int d_aw, input int d_w, input int d_b, input int d_ar,
                        input int d_r, input int stall);
    int n;
    int idx;
    logic [31:0] exp_dat;
    logic exp_err;
    idx = int'(addr[5:2]);
    aw_dly = d_aw; w_dly = d_w; b_dly = d_b; ar_dly = d_ar; r_dly = d_r;
    cur_resp = resp;
    exp_dat = we ? 32'h0 : rmem[idx];
    exp_err = (resp == 2'b10) || (resp == 2'b11);
    if (we && !exp_err) rmem[idx] = merge(rmem[idx], data, strb);

    req_val = 1; req_we = we; req_addr = addr; req_wdat = data; req_wstrb = strb;
    rsp_rdy = 0;
    n = 0;
    while (!req_rdy && n < 50) begin tick(); n++; end
    check("req_accept", req_rdy, 1'b1);
    acc_cyc = cyc;
    slave_clear();
    tick();
    req_val = 0; req_we = 1'($urandom); req_addr = $urandom; req_wdat = $urandom;
    req_wstrb = 4'($urandom);

    n = 0;
    while (!rsp_val && n < 200) begin
      check("req_rdy_busy", req_rdy, 1'b0);
      tick();
      n++;
    end
    t_rsp = cyc - acc_cyc;
    check("rsp_val", rsp_val, 1'b1);
    check("rsp_dat", rsp_dat, exp_dat);
    check("rsp_err", rsp_err, exp_err);
    if (we) begin
      check("aw_addr", got_awaddr, addr);
      check("w_data", {got_wdata, got_wstrb}, {data, strb});
      check("b_count", b_count, 1);
    end else begin
      check("ar_addr", got_araddr, addr);
      check("r_done", r_done, 1'b1);
    end

    for (int s = 0; s < stall; s++) begin
      tick();
      check("stall_val", rsp_val, 1'b1);
      check("stall_rsp", {rsp_dat, rsp_err}, {exp_dat, exp_err});
      check("stall_rdy", req_rdy, 1'b0);
    end
    rsp_rdy = 1;
    tick();
    rsp_rdy = 0;
    check("rsp_drop", rsp_val, 1'b0);
    check("b2b_rdy", req_rdy, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_cyc;
    for (int i = 0; i < 16; i++) begin smem[i] = '0; rmem[i] = '0; end
    rst = 1; req_val = 0; req_we = 0; req_addr = '0; req_wdat = '0; req_wstrb = '0;
    rsp_rdy = 0; cur_resp = 2'b00; cur_rdata = '0;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    slave_clear();

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ctrl", {req_rdy, rsp_val, rsp_err, axi_awvalid, axi_wvalid, axi_bready,
                       axi_arvalid, axi_rready}, 8'h00);
    check("rst_addr", {axi_awaddr, axi_araddr}, 64'h0);
    check("rst_data", {rsp_dat, axi_wdata, axi_wstrb}, 68'h0);
    rst = 0;
    tick();
    check("rdy_after_rst", req_rdy, 1'b1);

    // Read, zero-wait slave.
    smem[1] = 32'hDEADBEEF; rmem[1] = 32'hDEADBEEF;
    do_txn(0, 32'h1000_0004, 32'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0);
    check("rd_ar_cycle", t_ar_first, 1);
    check("rd_rready_cycle", t_r_first, 2);
    check("rd_rsp_cycle", t_rsp, 3);

    // Write, delayed W.
    do_txn(1, 32'h1000_0008, 32'h1234_5678, 4'hF, 2'b00, 0, 3, 0, 0, 0, 0);
    check("wd_aw_hs", t_aw_hs, 1);
    check("wd_w_first", t_w_first, 1);
    check("wd_w_hs", t_w_hs, 4);
    check("wd_bready", t_b_first, 5);

    // Write, W before AW.
    do_txn(1, 32'h1000_000C, 32'hCAFE_F00D, 4'h5, 2'b01, 2, 0, 0, 0, 0, 0);
    check("wa_w_hs", t_w_hs, 1);
    check("wa_aw_hs", t_aw_hs, 3);
    check("wa_bready", t_b_first, 4);

    // Error responses; the write is zero-wait so it also pins write latency.
    do_txn(0, 32'h1000_0008, 32'h0, 4'h0, 2'b11, 0, 0, 0, 0, 0, 0);
    do_txn(1, 32'h1000_0010, 32'hFFFF_FFFF, 4'hF, 2'b10, 0, 0, 0, 0, 0, 0);
    check("wz_aw_cycle", t_aw_first, 1);
    check("wz_bready", t_b_first, 2);
    check("wz_rsp_cycle", t_rsp, 3);

    // Stall then back-to-back read.
    do_txn(0, 32'h1000_000C, 32'h0, 4'h0, 2'b00, 1, 1, 1, 1, 1, 5);
    hs_cyc = cyc - 1;
    do_txn(0, 32'h1000_0008, 32'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0);
    check("b2b_accept", acc_cyc, hs_cyc + 1);

    // Reset while awvalid is high; the write must be abandoned.
    aw_dly = 20; w_dly = 20; cur_resp = 2'b00;
    req_val = 1; req_we = 1; req_addr = 32'h1000_000C; req_wdat = 32'h0BAD_0BAD; req_wstrb = 4'hF;
    begin
      int n;
      n = 0;
      while (!req_rdy && n < 50) begin tick(); n++; end
    end
    acc_cyc = cyc;
    slave_clear();
    aw_dly = 20; w_dly = 20;
    tick();
    req_val = 0;
    tick();
    check("mid_awvalid", axi_awvalid, 1'b1);
    rst = 1;
    #1;
    check("mid_rst_ctrl", {req_rdy, rsp_val, rsp_err, axi_awvalid, axi_wvalid, axi_bready,
                           axi_arvalid, axi_rready}, 8'h00);
    check("mid_rst_addr", {axi_awaddr, axi_araddr}, 64'h0);
    check("mid_rst_data", {rsp_dat, axi_wdata, axi_wstrb}, 68'h0);
    slave_clear();
    tick();
    tick();
    rst = 0;
    tick();
    check("mid_rdy_after", req_rdy, 1'b1);
    do_txn(0, 32'h1000_000C, 32'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0);
    check("mid_rd_cycle", t_rsp, 3);

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = 32'h1000_0000 | (32'($urandom_range(0, 15)) << 2);
      do_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
             2'($urandom_range(0, 3)), $urandom_range(0, 4), $urandom_range(0, 4),
             $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3),
             $urandom_range(0, 3));
    end

    // Read back every word with OKAY to confirm accumulated writes and strobes.
    for (int i = 0; i < 16; i++)
      do_txn(0, 32'h1000_0000 | (32'(i) << 2), 32'h0, 4'h0, 2'b00, 0, 0, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
